mc_ctrl: RTL and testbench

Multi-cycle control unit for the simple MIPS CPU. It decodes the opcode and funct fields of the instruction register and sequences the FETCH/DECODE/EXECUTE/MEM/WB states. Each cycle it produces the ALUOp, operand-select, write-enable and memory handshake signals for the datapath. It is the producer side of the ALUOp/zero interface: it drives ALUOp and consumes the ALU's zero flag for branch resolution.

---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/mc_ctrl_alu_dec.sv | 48 ++++
 rtl/mc_ctrl.sv | 147 ++++++++++++++
 tb/tb_mc_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: ALUOp codes, opcodes,
// funct values, FSM states and datapath select values.
package mc_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUOP_W = 5;
    localparam int unsigned SEL_W   = 2;

    localparam logic [ALUOP_W-1:0] ALU_ADDU = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUBU = 5'd1;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 5'd2;
    localparam logic [ALUOP_W-1:0] ALU_EQL  = 5'd3;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 5'd4;
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 5'd5;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 5'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 5'd7;
    localparam logic [ALUOP_W-1:0] ALU_BNE  = 5'd8;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 5'd9;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'b000000;

    localparam logic [SEL_W-1:0] A_PC      = 2'd0;
    localparam logic [SEL_W-1:0] A_RS      = 2'd1;
    localparam logic [SEL_W-1:0] A_RT      = 2'd2;
    localparam logic [SEL_W-1:0] B_RT      = 2'd0;
    localparam logic [SEL_W-1:0] B_FOUR    = 2'd1;
    localparam logic [SEL_W-1:0] B_IMM     = 2'd2;
    localparam logic [SEL_W-1:0] B_IMM_SH2 = 2'd3;
    localparam logic [SEL_W-1:0] PC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP
    } state_e;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW)  ||
               (op == OP_ADDI)  || (op == OP_ORI) || (op == OP_LUI) ||
               (op == OP_BEQ)   || (op == OP_BNE) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// Combinational ALUOp / EXTOp decode from the current state and the IR fields;
// also flags an unsupported R-type funct.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  state_e               state_i,
    input  logic [OP_W-1:0]      op_i,
    input  logic [FUNCT_W-1:0]   funct_i,
    output logic [ALUOP_W-1:0]   aluop_o,
    output logic                 extop_o,
    output logic                 funct_ok_o
);

    always_comb begin
        aluop_o    = ALU_ADDU;
        extop_o    = 1'b0;
        funct_ok_o = 1'b1;
        case (state_i)
            S_DECODE, S_MEMADR: extop_o = 1'b1;
            S_EXEC_R: begin
                case (funct_i)
                    FN_ADDU: aluop_o = ALU_ADDU;
                    FN_SUBU: aluop_o = ALU_SUBU;
                    FN_ADD:  aluop_o = ALU_ADD;
                    FN_SUB:  aluop_o = ALU_SUB;
                    FN_OR:   aluop_o = ALU_OR;
                    FN_SLT:  aluop_o = ALU_SLT;
                    FN_SLL:  aluop_o = ALU_SLL;
                    default: funct_ok_o = 1'b0;
                endcase
            end
            S_EXEC_I: begin
                case (op_i)
                    OP_ADDI: begin
                        aluop_o = ALU_ADD;
                        extop_o = 1'b1;
                    end
                    OP_ORI:  aluop_o = ALU_OR;
                    OP_LUI:  aluop_o = ALU_LUI;
                    default: aluop_o = ALU_ADDU;
                endcase
            end
            S_BRANCH: aluop_o = (op_i == OP_BNE) ? ALU_BNE : ALU_EQL;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH..WB and drives the datapath
// selects, write enables and memory handshake combinationally from state and IR.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit RESET_PC_WR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_W-1:0]      Op,
    input  logic [FUNCT_W-1:0]   Funct,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 PCWr,
    output logic                 IRWr,
    output logic                 MemRd,
    output logic                 MemWr,
    output logic                 IorD,
    output logic                 RegWr,
    output logic                 RegDst,
    output logic                 WDSel,
    output logic                 EXTOp,
    output logic [SEL_W-1:0]     ALUSrcA,
    output logic [SEL_W-1:0]     ALUSrcB,
    output logic [ALUOP_W-1:0]   ALUOp,
    output logic [SEL_W-1:0]     PCSource,
    output logic                 illegal
);

    state_e state_q, state_d;
    logic   pcwr_c, irwr_c, regwr_c, memwr_c;
    logic   funct_ok_c;

    mc_alu_dec u_alu_dec (
        .state_i    (state_q),
        .op_i       (Op),
        .funct_i    (Funct),
        .aluop_o    (ALUOp),
        .extop_o    (EXTOp),
        .funct_ok_o (funct_ok_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pcwr_c   = 1'b0;
        irwr_c   = 1'b0;
        regwr_c  = 1'b0;
        memwr_c  = 1'b0;
        MemRd    = 1'b0;
        IorD     = 1'b0;
        RegDst   = 1'b0;
        WDSel    = 1'b0;
        ALUSrcA  = A_PC;
        ALUSrcB  = B_FOUR;
        PCSource = PC_ALU;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRd  = 1'b1;
                pcwr_c = mem_ready;
                irwr_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            // Branch target is precomputed here into ALUOut.
            S_DECODE: begin
                ALUSrcB = B_IMM_SH2;
                case (Op)
                    OP_LW, OP_SW:            state_d = S_MEMADR;
                    OP_RTYPE:                state_d = S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    OP_J:                    state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            // sll takes rt as A and the immediate field as B (shamt in B[10:6]).
            S_EXEC_R: begin
                ALUSrcA = (Funct == FN_SLL) ? A_RT  : A_RS;
                ALUSrcB = (Funct == FN_SLL) ? B_IMM : B_RT;
                if (funct_ok_c) begin
                    state_d = S_ALUWB;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_I: begin
                ALUSrcA = A_RS;
                ALUSrcB = B_IMM;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwr_c = 1'b1;
                RegDst  = (Op == OP_RTYPE);
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA = A_RS;
                ALUSrcB = B_IMM;
                state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwr_c = 1'b1;
                WDSel   = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                memwr_c = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = A_RS;
                ALUSrcB  = B_RT;
                PCSource = PC_ALUOUT;
                pcwr_c   = Zero;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSource = PC_JUMP;
                pcwr_c   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural writes are held off for the whole reset window.
    assign PCWr  = rst ? RESET_PC_WR : pcwr_c;
    assign IRWr  = rst ? RESET_PC_WR : irwr_c;
    assign RegWr = rst ? RESET_PC_WR : regwr_c;
    assign MemWr = rst ? RESET_PC_WR : memwr_c;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction cycle plans expand into expected
// output vectors that a negedge monitor compares against the DUT.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] T_ADDI = 6'b001000, T_ORI = 6'b001101, T_LUI = 6'b001111;
    localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_J = 6'b000010;

    localparam int P_FETCH = 0, P_DECODE = 1, P_EXR = 2, P_EXI = 3, P_ALUWB = 4;
    localparam int P_MEMADR = 5, P_MEMRD = 6, P_MEMWB = 7, P_MEMWR = 8, P_BR = 9, P_JMP = 10;

    logic       clk, rst, Zero, mem_ready;
    logic [5:0] Op, Funct;
    logic       PCWr, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, WDSel, EXTOp, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, PCSource;
    logic [4:0] ALUOp;

    typedef struct packed {
        logic pcwr, irwr, memrd, memwr, iord, regwr, regdst, wdsel, extop;
        logic [1:0] srca, srcb;
        logic [4:0] aluop;
        logic [1:0] pcsrc;
        logic illegal;
    } ov_t;

    typedef struct { ov_t val; ov_t care; int ph; } chk_t;
    typedef struct { int ph; logic mr; logic z; } cyc_t;

    chk_t exp_q[$];
    cyc_t plan_q[$];
    int   vectors = 0;
    int   errors  = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr), .IorD(IorD),
        .RegWr(RegWr), .RegDst(RegDst), .WDSel(WDSel), .EXTOp(EXTOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string ph_name(input int ph);
        case (ph)
            P_FETCH: return "fetch";    P_DECODE: return "decode";
            P_EXR:   return "exec_r";   P_EXI:    return "exec_i";
            P_ALUWB: return "alu_wb";   P_MEMADR: return "mem_adr";
            P_MEMRD: return "mem_rd";   P_MEMWB:  return "mem_wb";
            P_MEMWR: return "mem_wr";   P_BR:     return "branch";
            default: return "jump";
        endcase
    endfunction

    // R-type funct -> ALUOp; -1 marks an unsupported funct.
    function automatic int r_alu(input logic [5:0] fn);
        case (fn)
            6'b100001: return int'(ALU_ADDU);
            6'b100011: return int'(ALU_SUBU);
            6'b100000: return int'(ALU_ADD);
            6'b100010: return int'(ALU_SUB);
            6'b100101: return int'(ALU_OR);
            6'b101010: return int'(ALU_SLT);
            6'b000000: return int'(ALU_SLL);
            default:   return -1;
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        return op inside {T_R, T_LW, T_SW, T_ADDI, T_ORI, T_LUI, T_BEQ, T_BNE, T_J};
    endfunction

    function automatic chk_t expect_of(input cyc_t c, input logic [5:0] op, input logic [5:0] fn);
        chk_t e;
        e.val  = '0;
        e.care = '0;
        e.ph   = c.ph;
        e.care.pcwr = 1'b1; e.care.irwr = 1'b1; e.care.memrd = 1'b1;
        e.care.memwr = 1'b1; e.care.regwr = 1'b1; e.care.illegal = 1'b1;
        case (c.ph)
            P_FETCH: begin
                e.val.memrd = 1'b1; e.val.pcwr = c.mr; e.val.irwr = c.mr;
                e.val.srcb = 2'd1; e.val.aluop = ALU_ADDU;
                e.care.iord = 1'b1; e.care.srca = '1; e.care.srcb = '1;
                e.care.aluop = '1; e.care.pcsrc = '1;
            end
            P_DECODE: begin
                e.val.srcb = 2'd3; e.val.aluop = ALU_ADDU; e.val.extop = 1'b1;
                e.val.illegal = !op_known(op);
                e.care.srca = '1; e.care.srcb = '1; e.care.aluop = '1; e.care.extop = 1'b1;
            end
            P_EXR: begin
                if (r_alu(fn) < 0) begin
                    e.val.illegal = 1'b1;
                end else begin
                    e.val.aluop = 5'(r_alu(fn));
                    e.val.srca  = (fn == 6'b000000) ? 2'd2 : 2'd1;
                    e.val.srcb  = (fn == 6'b000000) ? 2'd2 : 2'd0;
                    e.care.aluop = '1; e.care.srca = '1; e.care.srcb = '1;
                end
            end
            P_EXI: begin
                e.val.srca = 2'd1; e.val.srcb = 2'd2;
                e.val.aluop = (op == T_ADDI) ? ALU_ADD : (op == T_ORI) ? ALU_OR : ALU_LUI;
                e.val.extop = (op == T_ADDI);
                e.care.srca = '1; e.care.srcb = '1; e.care.aluop = '1; e.care.extop = 1'b1;
            end
            P_ALUWB: begin
                e.val.regwr = 1'b1; e.val.regdst = (op == T_R);
                e.care.wdsel = 1'b1; e.care.regdst = 1'b1;
            end
            P_MEMADR: begin
                e.val.srca = 2'd1; e.val.srcb = 2'd2; e.val.extop = 1'b1; e.val.aluop = ALU_ADDU;
                e.care.srca = '1; e.care.srcb = '1; e.care.aluop = '1; e.care.extop = 1'b1;
            end
            P_MEMRD: begin
                e.val.memrd = 1'b1; e.val.iord = 1'b1; e.care.iord = 1'b1;
            end
            P_MEMWB: begin
                e.val.regwr = 1'b1; e.val.wdsel = 1'b1;
                e.care.wdsel = 1'b1; e.care.regdst = 1'b1;
            end
            P_MEMWR: begin
                e.val.memwr = 1'b1; e.val.iord = 1'b1; e.care.iord = 1'b1;
            end
            P_BR: begin
                e.val.srca = 2'd1; e.val.pcsrc = 2'd1; e.val.pcwr = c.z;
                e.val.aluop = (op == T_BNE) ? ALU_BNE : ALU_EQL;
                e.care.srca = '1; e.care.srcb = '1; e.care.pcsrc = '1; e.care.aluop = '1;
            end
            default: begin
                e.val.pcsrc = 2'd2; e.val.pcwr = 1'b1; e.care.pcsrc = '1;
            end
        endcase
        return e;
    endfunction

    task automatic add_cyc(input int ph, input logic mr, input int zf);
        cyc_t c;
        c.ph = ph;
        c.mr = mr;
        c.z  = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
        plan_q.push_back(c);
    endtask

    // Memory phase: wait cycles with mem_ready low, then one completing cycle.
    task automatic add_mem(input int ph, input int waits, input int zf);
        int n;
        n = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
        for (int i = 0; i < n; i++) add_cyc(ph, 1'b0, zf);
        add_cyc(ph, 1'b1, zf);
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int waits, input int zf);
        plan_q.delete();
        add_mem(P_FETCH, waits, zf);
        add_cyc(P_DECODE, 1'($urandom_range(0, 1)), zf);
        case (op)
            T_R: begin
                add_cyc(P_EXR, 1'($urandom_range(0, 1)), zf);
                if (r_alu(fn) >= 0) add_cyc(P_ALUWB, 1'($urandom_range(0, 1)), zf);
            end
            T_LW: begin
                add_cyc(P_MEMADR, 1'($urandom_range(0, 1)), zf);
                add_mem(P_MEMRD, waits, zf);
                add_cyc(P_MEMWB, 1'($urandom_range(0, 1)), zf);
            end
            T_SW: begin
                add_cyc(P_MEMADR, 1'($urandom_range(0, 1)), zf);
                add_mem(P_MEMWR, waits, zf);
            end
            T_ADDI, T_ORI, T_LUI: begin
                add_cyc(P_EXI, 1'($urandom_range(0, 1)), zf);
                add_cyc(P_ALUWB, 1'($urandom_range(0, 1)), zf);
            end
            T_BEQ, T_BNE: add_cyc(P_BR, 1'($urandom_range(0, 1)), zf);
            T_J:          add_cyc(P_JMP, 1'($urandom_range(0, 1)), zf);
            default: ;
        endcase
        foreach (plan_q[i]) begin
            Op        = op;
            Funct     = fn;
            mem_ready = plan_q[i].mr;
            Zero      = plan_q[i].z;
            exp_q.push_back(expect_of(plan_q[i], op, fn));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk1(input string nm, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    ov_t  act_v;
    chk_t mon_e;
    logic [$bits(ov_t)-1:0] diff_v;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            act_v = '{PCWr, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, WDSel, EXTOp,
                      ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};
            diff_v = (act_v ^ mon_e.val) & mon_e.care;
            vectors++;
            if (diff_v != '0) begin
                errors++;
                $display("FAIL %s @%0t: got %h want %h (care %h)", ph_name(mon_e.ph),
                         $time, act_v, mon_e.val, mon_e.care);
            end
        end
    end

    logic [5:0] ops_tab [9];
    logic [5:0] fns_tab [7];

    initial begin
        ops_tab = '{T_R, T_LW, T_SW, T_ADDI, T_ORI, T_LUI, T_BEQ, T_BNE, T_J};
        fns_tab = '{6'b100001, 6'b100011, 6'b100000, 6'b100010, 6'b100101, 6'b101010, 6'b000000};
        rst = 1'b1; mem_ready = 1'b1; Zero = 1'b1; Op = T_LW; Funct = 6'b0;
        #12;
        chk1("rst_pcwr",  8'(PCWr),    8'd0);
        chk1("rst_irwr",  8'(IRWr),    8'd0);
        chk1("rst_regwr", 8'(RegWr),   8'd0);
        chk1("rst_memwr", 8'(MemWr),   8'd0);
        chk1("rst_aluop", 8'(ALUOp),   8'(ALU_ADDU));
        chk1("rst_srca",  8'(ALUSrcA), 8'd0);
        chk1("rst_srcb",  8'(ALUSrcB), 8'd1);
        chk1("rst_ill",   8'(illegal), 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(T_R, 6'b100001, 0, -1);
        issue(T_R, 6'b000000, 0, -1);
        issue(T_LUI, 6'b010101, 0, -1);
        issue(T_LW, 6'b000000, 3, -1);
        issue(T_BEQ, 6'b000000, 0, 1);
        issue(T_BEQ, 6'b000000, 0, 0);
        issue(T_BNE, 6'b000000, 0, -1);
        issue(T_J, 6'b000000, 0, -1);
        issue(6'b111111, 6'b000000, 0, -1);
        issue(T_R, 6'b111111, 0, -1);
        issue(T_SW, 6'b000000, 2, -1);
        issue(T_ADDI, 6'b000000, 0, -1);
        issue(T_ORI, 6'b000000, 1, -1);

        for (int n = 0; n < 120; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops_tab[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns_tab[$urandom_range(0, 6)];
            issue(op, fn, -1, -1);
        end

        // Reset in the middle of a stalled store.
        Op = T_SW; Funct = 6'b0; mem_ready = 1'b1; Zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1;
        chk1("sw_stall_memwr", 8'(MemWr), 8'd1);
        rst = 1'b1;
        #1;
        chk1("mid_rst_memwr", 8'(MemWr), 8'd0);
        chk1("mid_rst_pcwr",  8'(PCWr),  8'd0);
        mem_ready = 1'b1;
        #1;
        chk1("mid_rst_pcwr_rdy", 8'(PCWr), 8'd0);
        chk1("mid_rst_irwr_rdy", 8'(IRWr), 8'd0);
        @(posedge clk); #1;
        chk1("held_rst_pcwr",  8'(PCWr),  8'd0);
        chk1("held_rst_memwr", 8'(MemWr), 8'd0);
        rst = 1'b0;
        issue(T_R, 6'b100001, 0, -1);

        @(posedge clk); #1;
        chk1("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
